// File: rtl/counter_cmd_sched.sv
// Round-robin scheduler that time-shares one external up/down counter between NREQ requesters.
// Each granted command loads a start value, steps the counter len times, then reports the result.
module counter_cmd_sched #(
    parameter  int SIZE = 2,
    parameter  int NREQ = 2,
    parameter  int LENW = 4,
    localparam int CMDW = 1 + SIZE + LENW,
    localparam int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*CMDW-1:0] req_cmd,
    output logic                 cnt_load,
    output logic [SIZE-1:0]      cnt_data,
    output logic                 cnt_up_dwn,
    input  logic [SIZE-1:0]      cnt_out,
    output logic                 done,
    output logic [IDW-1:0]       done_id,
    output logic [SIZE-1:0]      done_value,
    output logic [1:0]           state_dbg
);

    // Handshake: a requester's command is taken on the rising edge where req_valid[i] and
    // req_ready[i] are both high; req_valid must be held until that edge.

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [IDW:0]   NREQ_W  = (IDW + 1)'(NREQ);
    localparam logic [IDW-1:0] LAST_ID = IDW'(NREQ - 1);

    state_t            state, state_nxt;
    logic [IDW-1:0]    rr_ptr;
    logic [IDW-1:0]    grant_id;
    logic              cmd_dir;
    logic [SIZE-1:0]   cmd_start;
    logic [LENW-1:0]   cmd_len;
    logic [LENW-1:0]   remaining;

    logic              any_valid;
    logic [IDW-1:0]    grant;
    logic [IDW:0]      scan_sum;
    logic [IDW-1:0]    scan_idx;
    logic [CMDW-1:0]   sel_cmd;

    // First valid requester at or after rr_ptr, wrapping at NREQ.
    always_comb begin
        any_valid = 1'b0;
        grant     = '0;
        scan_sum  = '0;
        scan_idx  = '0;
        for (int k = 0; k < NREQ; k++) begin
            scan_sum = {1'b0, rr_ptr} + (IDW + 1)'(k);
            if (scan_sum >= NREQ_W) begin
                scan_sum = scan_sum - NREQ_W;
            end
            scan_idx = scan_sum[IDW-1:0];
            if (!any_valid && req_valid[scan_idx]) begin
                any_valid = 1'b1;
                grant     = scan_idx;
            end
        end
    end

    always_comb begin
        sel_cmd = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant == IDW'(i)) begin
                sel_cmd = req_cmd[i*CMDW +: CMDW];
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (any_valid) state_nxt = LOAD;
            LOAD: state_nxt = (cmd_len == '0) ? DONE : RUN;
            RUN:  if (remaining == LENW'(1)) state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            remaining <= '0;
            grant_id  <= '0;
            cmd_dir   <= 1'b0;
            cmd_start <= '0;
            cmd_len   <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (any_valid) begin
                        grant_id  <= grant;
                        cmd_dir   <= sel_cmd[CMDW-1];
                        cmd_start <= sel_cmd[LENW +: SIZE];
                        cmd_len   <= sel_cmd[LENW-1:0];
                        rr_ptr    <= (grant == LAST_ID) ? '0 : grant + IDW'(1);
                    end
                end
                LOAD: remaining <= cmd_len;
                RUN:  remaining <= remaining - LENW'(1);
                default: ;
            endcase
        end
    end

    // Outside RUN the counter is reloaded with its own value so it holds.
    always_comb begin
        req_ready  = '0;
        for (int i = 0; i < NREQ; i++) begin
            req_ready[i] = !reset && (state == IDLE) && any_valid && (grant == IDW'(i));
        end
        cnt_load   = reset || (state != RUN);
        cnt_data   = (state == LOAD) ? cmd_start : cnt_out;
        cnt_up_dwn = cmd_dir;
        done       = !reset && (state == DONE);
        done_id    = done ? grant_id : '0;
        done_value = done ? cnt_out : '0;
        state_dbg  = state;
    end

endmodule

// File: tb/tb_counter_cmd_sched.sv
// Directed bench for counter_cmd_sched with a behavioural up/down counter model attached.
module tb_counter_cmd_sched;

    localparam int SIZE = 2;
    localparam int NREQ = 2;
    localparam int LENW = 4;
    localparam int CMDW = 1 + SIZE + LENW;
    localparam int IDW  = 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_RUN  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    // clock / reset
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ*CMDW-1:0] req_cmd;
    logic                 cnt_load;
    logic [SIZE-1:0]      cnt_data;
    logic                 cnt_up_dwn;
    logic [SIZE-1:0]      cnt_out;
    logic                 done;
    logic [IDW-1:0]       done_id;
    logic [SIZE-1:0]      done_value;
    logic [1:0]           state_dbg;

    int checks = 0;
    int errors = 0;

    counter_cmd_sched #(.SIZE(SIZE), .NREQ(NREQ), .LENW(LENW)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_cmd    (req_cmd),
        .cnt_load   (cnt_load),
        .cnt_data   (cnt_data),
        .cnt_up_dwn (cnt_up_dwn),
        .cnt_out    (cnt_out),
        .done       (done),
        .done_id    (done_id),
        .done_value (done_value),
        .state_dbg  (state_dbg)
    );

    // Shared counter: synchronous reset to 0, load wins, otherwise step up or down.
    always @(posedge clk) begin
        if (reset)           cnt_out <= '0;
        else if (cnt_load)   cnt_out <= cnt_data;
        else if (cnt_up_dwn) cnt_out <= cnt_out + 2'd1;
        else                 cnt_out <= cnt_out - 2'd1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // Drives one command from requester id, starting in an IDLE cycle, and checks every cycle.
    task automatic run_cmd(input int id, input bit dir, input bit [1:0] start,
                           input bit [3:0] len, input bit [1:0] exp_val);
        logic [1:0] e;
        req_cmd[id*CMDW +: CMDW] = {dir, start, len};
        req_valid     = '0;
        req_valid[id] = 1'b1;
        #1;
        chk("grant_idle", state_dbg, S_IDLE);
        chk("grant_ready", req_ready, 32'(1) << id);
        step();
        req_valid = '0;
        #1;
        chk("load_state", state_dbg, S_LOAD);
        chk("load_cnt_load", cnt_load, 1);
        chk("load_cnt_data", cnt_data, start);
        chk("load_ready", req_ready, 0);
        for (int i = 0; i < len; i++) begin
            step();
            e = dir ? start + 2'(i) : start - 2'(i);
            chk("run_state", state_dbg, S_RUN);
            chk("run_cnt_load", cnt_load, 0);
            chk("run_dir", cnt_up_dwn, dir);
            chk("run_cnt_out", cnt_out, e);
            chk("run_no_done", done, 0);
        end
        step();
        chk("done_pulse", done, 1);
        chk("done_id", done_id, id);
        chk("done_value", done_value, exp_val);
        chk("done_cnt_load", cnt_load, 1);
        step();
        chk("after_done", done, 0);
        chk("after_done_value", done_value, 0);
        chk("after_done_state", state_dbg, S_IDLE);
    endtask

    initial begin
        reset     = 1'b1;
        req_valid = '0;
        req_cmd   = '0;
        step();
        chk("rst_done", done, 0);
        chk("rst_ready", req_ready, 0);
        chk("rst_cnt_load", cnt_load, 1);
        step();
        reset = 1'b0;
        #1;
        chk("rst_state", state_dbg, S_IDLE);
        chk("rst_cnt_out", cnt_out, 0);
        chk("rst_done_id", done_id, 0);
        chk("rst_done_value", done_value, 0);
        chk("rst_cnt_data", cnt_data, 0);

        // basic up count, wrap cases, zero-length command
        run_cmd(0, 1'b1, 2'd1, 4'd2, 2'd3);
        run_cmd(1, 1'b1, 2'd3, 4'd1, 2'd0);
        run_cmd(1, 1'b0, 2'd0, 4'd1, 2'd3);
        run_cmd(1, 1'b0, 2'd2, 4'd6, 2'd0);
        run_cmd(0, 1'b0, 2'd2, 4'd0, 2'd2);

        // idle hold after a done with value 2
        for (int i = 0; i < 10; i++) begin
            chk("hold_cnt_out", cnt_out, 2);
            chk("hold_cnt_load", cnt_load, 1);
            chk("hold_ready", req_ready, 0);
            step();
        end

        // both requesters valid continuously after reset: strict alternation
        reset = 1'b1;
        step();
        reset = 1'b0;
        req_cmd   = {{1'b0, 2'd2, 4'd0}, {1'b1, 2'd1, 4'd0}};
        req_valid = 2'b11;
        #1;
        for (int n = 0; n < 4; n++) begin
            chk("rr_ready", req_ready, (n % 2 == 0) ? 2'b01 : 2'b10);
            step();
            chk("rr_load_ready", req_ready, 0);
            step();
            chk("rr_done", done, 1);
            chk("rr_done_id", done_id, n % 2);
            chk("rr_done_value", done_value, (n % 2 == 0) ? 1 : 2);
            chk("rr_done_ready", req_ready, 0);
            step();
        end

        // reset in the second RUN cycle abandons the command
        req_valid = '0;
        reset     = 1'b1;
        step();
        reset     = 1'b0;
        req_cmd   = '0;
        req_cmd[CMDW-1:0] = {1'b1, 2'd1, 4'd3};
        req_valid = 2'b01;
        #1;
        chk("ab_ready0", req_ready, 2'b01);
        step();
        chk("ab_load", state_dbg, S_LOAD);
        step();
        chk("ab_run1_cnt", cnt_out, 1);
        step();
        chk("ab_run2_cnt", cnt_out, 2);
        reset = 1'b1;
        #1;
        chk("ab_rst_done", done, 0);
        chk("ab_rst_ready", req_ready, 0);
        step();
        reset = 1'b0;
        #1;
        chk("ab_idle_state", state_dbg, S_IDLE);
        chk("ab_idle_cnt", cnt_out, 0);
        chk("ab_idle_done", done, 0);
        chk("ab_regrant", req_ready, 2'b01);
        step();
        req_valid = '0;
        chk("ab_load2", state_dbg, S_LOAD);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("ab_run_no_done", done, 0);
        end
        step();
        chk("ab_done", done, 1);
        chk("ab_done_value", done_value, 0);
        chk("ab_done_id", done_id, 0);
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
